// File: rtl/axi_fifo_bridge.sv
// axi_fifo_bridge: AXI4-Lite slave that converts host register writes into a TX word
// stream toward the core and returns core results through an RX FIFO read register.
// Register map (addr[3:2]): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL.
// Optional feature macro: AXI_FIFO_BRIDGE_IRQ_EN adds a registered irq output and
// makes CTRL bit2 (IRQ_ENABLE) read/write.
module axi_fifo_bridge #(
  parameter int unsigned S_AXI_DATA_WIDTH = 32,
  parameter int unsigned S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH       = 8
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                    s_axi_awprot,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                    s_axi_arprot,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [S_AXI_DATA_WIDTH-1:0]   m_tx_tdata,
  output logic                          m_tx_tvalid,
  input  logic                          m_tx_tready,
  input  logic [S_AXI_DATA_WIDTH-1:0]   s_rx_tdata,
  input  logic                          s_rx_tvalid,
  output logic                          s_rx_tready
`ifdef AXI_FIFO_BRIDGE_IRQ_EN
  ,
  output logic                          irq
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DW   = S_AXI_DATA_WIDTH;

  localparam logic [1:0] AddrTx     = 2'd0;
  localparam logic [1:0] AddrRx     = 2'd1;
  localparam logic [1:0] AddrStatus = 2'd2;
  localparam logic [1:0] AddrCtrl   = 2'd3;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam logic [0:0] WIdle = 1'b0;
  localparam logic [0:0] WResp = 1'b1;
  localparam logic [0:0] RIdle = 1'b0;
  localparam logic [0:0] RData = 1'b1;

  // Goes high one cycle after reset release; holds s_rx_tready low during reset.
  logic alive_q, alive_d;

  // TX FIFO
  logic [DW-1:0]   tx_mem_q [FIFO_DEPTH];
  logic [DW-1:0]   tx_mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;

  // RX FIFO
  logic [DW-1:0]   rx_mem_q [FIFO_DEPTH];
  logic [DW-1:0]   rx_mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;

  // Write channel
  logic [0:0]    w_state_q, w_state_d;
  logic          awready_q, awready_d, wready_q, wready_d;
  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [1:0]    waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wstrb_nz_q, wstrb_nz_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;

  // Read channel
  logic [0:0]    r_state_q, r_state_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

  // Sticky flags
  logic tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

`ifdef AXI_FIFO_BRIDGE_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;
`endif

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          aw_hs, w_hs, ar_hs;
  logic          commit, commit_act;
  logic          tx_push_req, tx_push, tx_pop, tx_ovf_evt;
  logic          rx_push, rx_pop, rd_rx, rx_unf_evt;
  logic          flush, clr_sticky;
  logic [31:0]   status_word;
  logic [DW-1:0] ctrl_word, rd_word, rx_head;
  logic          unused_inputs;

  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

  assign tx_full  = (tx_cnt_q == CntW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CntW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign aw_hs = s_axi_awvalid && awready_q;
  assign w_hs  = s_axi_wvalid && wready_q;
  assign ar_hs = s_axi_arvalid && arready_q;

  // Decode the committed write and the read handshake into FIFO/flag events.
  always_comb begin
    commit      = (w_state_q == WIdle) && aw_held_q && w_held_q;
    commit_act  = commit && wstrb_nz_q;
    tx_push_req = commit_act && (waddr_q == AddrTx);
    tx_ovf_evt  = tx_push_req && tx_full;
    flush       = commit_act && (waddr_q == AddrCtrl) && wdata_q[0];
    clr_sticky  = commit_act && (waddr_q == AddrCtrl) && wdata_q[1];
    // Flush dominates same-cycle push/pop on both FIFOs.
    tx_push     = tx_push_req && !tx_full && !flush;
    tx_pop      = m_tx_tvalid && m_tx_tready && !flush;
    rd_rx       = ar_hs && (s_axi_araddr[3:2] == AddrRx);
    rx_unf_evt  = rd_rx && rx_empty;
    rx_pop      = rd_rx && !rx_empty && !flush;
    rx_push     = s_rx_tvalid && s_rx_tready && !flush;
  end

  assign m_tx_tdata  = tx_mem_q[tx_rd_ptr_q];
  assign m_tx_tvalid = !tx_empty;
  assign s_rx_tready = alive_q && !rx_full;
  assign rx_head     = rx_mem_q[rx_rd_ptr_q];

  // FIFO pointer, count and storage next-state.
  always_comb begin
    alive_d     = 1'b1;
    tx_mem_d    = tx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (flush) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_cnt_d    = '0;
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_cnt_d    = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wr_ptr_q] = wdata_q;
        tx_wr_ptr_d = tx_wr_ptr_q + PtrW'(1);
      end
      if (tx_pop) tx_rd_ptr_d = tx_rd_ptr_q + PtrW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_d = tx_cnt_q + CntW'(1);
        2'b01:   tx_cnt_d = tx_cnt_q - CntW'(1);
        default: tx_cnt_d = tx_cnt_q;
      endcase
      if (rx_push) begin
        rx_mem_d[rx_wr_ptr_q] = s_rx_tdata;
        rx_wr_ptr_d = rx_wr_ptr_q + PtrW'(1);
      end
      if (rx_pop) rx_rd_ptr_d = rx_rd_ptr_q + PtrW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_d = rx_cnt_q + CntW'(1);
        2'b01:   rx_cnt_d = rx_cnt_q - CntW'(1);
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end
  end

  // Sticky error flags: clear request first, new events override it.
  always_comb begin
    tx_ovf_d = clr_sticky ? 1'b0 : tx_ovf_q;
    rx_unf_d = clr_sticky ? 1'b0 : rx_unf_q;
    if (tx_ovf_evt) tx_ovf_d = 1'b1;
    if (rx_unf_evt) rx_unf_d = 1'b1;
  end

`ifdef AXI_FIFO_BRIDGE_IRQ_EN
  // IRQ enable register and registered interrupt output.
  always_comb begin
    irq_en_d = irq_en_q;
    if (commit_act && (waddr_q == AddrCtrl)) irq_en_d = wdata_q[2];
    irq_d = irq_en_q && (!rx_empty || tx_ovf_q || rx_unf_q);
  end
  assign irq       = irq_q;
  assign ctrl_word = DW'({irq_en_q, 2'b00});
`else
  assign ctrl_word = '0;
`endif

  assign status_word = {10'd0, rx_unf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full,
                        8'(rx_cnt_q), 8'(tx_cnt_q)};

  // Read data mux, sampled on the AR handshake.
  always_comb begin
    rd_word = '0;
    unique case (s_axi_araddr[3:2])
      AddrTx:     rd_word = '0;
      AddrRx:     rd_word = rx_empty ? '0 : rx_head;
      AddrStatus: rd_word = DW'(status_word);
      AddrCtrl:   rd_word = ctrl_word;
    endcase
  end

  // Write FSM: independent AW/W capture, commit once both held, hold B until bready.
  always_comb begin
    w_state_d  = w_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_nz_d = wstrb_nz_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    unique case (w_state_q)
      WIdle: begin
        if (commit) begin
          w_state_d = WResp;
          bvalid_d  = 1'b1;
          bresp_d   = tx_ovf_evt ? RespSlverr : RespOkay;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            awready_d = 1'b0;
            waddr_d   = s_axi_awaddr[3:2];
          end else if (!aw_held_q) begin
            awready_d = 1'b1;
          end
          if (w_hs) begin
            w_held_d   = 1'b1;
            wready_d   = 1'b0;
            wdata_d    = s_axi_wdata;
            wstrb_nz_d = |s_axi_wstrb;
          end else if (!w_held_q) begin
            wready_d = 1'b1;
          end
        end
      end
      WResp: begin
        if (s_axi_bready) begin
          w_state_d = WIdle;
          bvalid_d  = 1'b0;
          bresp_d   = RespOkay;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
    endcase
  end

  // Read FSM: register data/response on AR handshake, hold until rready.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          r_state_d = RData;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_word;
          rresp_d   = rx_unf_evt ? RespSlverr : RespOkay;
        end else begin
          arready_d = 1'b1;
        end
      end
      RData: begin
        if (s_axi_rready) begin
          r_state_d = RIdle;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
          rdata_d   = '0;
          rresp_d   = RespOkay;
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      alive_q     <= 1'b0;
      tx_mem_q    <= '{default: '0};
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_mem_q    <= '{default: '0};
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      w_state_q   <= WIdle;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wstrb_nz_q  <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RespOkay;
      r_state_q   <= RIdle;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RespOkay;
      tx_ovf_q    <= 1'b0;
      rx_unf_q    <= 1'b0;
`ifdef AXI_FIFO_BRIDGE_IRQ_EN
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      alive_q     <= alive_d;
      tx_mem_q    <= tx_mem_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_mem_q    <= rx_mem_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      w_state_q   <= w_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wstrb_nz_q  <= wstrb_nz_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      r_state_q   <= r_state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_unf_q    <= rx_unf_d;
`ifdef AXI_FIFO_BRIDGE_IRQ_EN
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
`endif
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_fifo_bridge.sv
// Self-checking bench for axi_fifo_bridge: a directed vector table for single
// register accesses plus hand-written multi-cycle sequences.
module tb_axi_fifo_bridge;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic [31:0] rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready;
`ifdef AXI_FIFO_BRIDGE_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;

  axi_fifo_bridge #(
    .S_AXI_DATA_WIDTH(32),
    .S_AXI_ADDR_WIDTH(4),
    .FIFO_DEPTH(8)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr),
    .s_axi_awprot(awprot),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_araddr(araddr),
    .s_axi_arprot(arprot),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata(rdata),
    .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid),
    .s_axi_rready(rready),
    .m_tx_tdata(tx_tdata),
    .m_tx_tvalid(tx_tvalid),
    .m_tx_tready(tx_tready),
    .s_rx_tdata(rx_tdata),
    .s_rx_tvalid(rx_tvalid),
    .s_rx_tready(rx_tready)
`ifdef AXI_FIFO_BRIDGE_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake timeout", name);
  endtask

  // All tasks start and end at #1 after a rising edge.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_p, w_p, aw_f, w_f;
    int cyc;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_p = 1'b1; w_p = 1'b1; cyc = 0;
    while ((aw_p || w_p) && cyc < 50) begin
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(posedge clk); #1; cyc++;
      if (aw_f) begin awvalid = 1'b0; aw_p = 1'b0; end
      if (w_f) begin wvalid = 1'b0; w_p = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; cyc = 0;
    while (!bvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    resp = bresp;
    if (!bvalid) timeout("write_b");
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_f;
    int cyc;
    araddr = a; arvalid = 1'b1; cyc = 0; ar_f = 1'b0;
    while (!ar_f && cyc < 50) begin
      ar_f = arready;
      @(posedge clk); #1; cyc++;
    end
    arvalid = 1'b0;
    if (!ar_f) timeout("read_ar");
    rready = 1'b1; cyc = 0;
    while (!rvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    d = rdata; resp = rresp;
    if (!rvalid) timeout("read_r");
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check({name, "_data"}, d, exp_d);
    check({name, "_resp"}, 32'(r), 32'(exp_r));
  endtask

  task automatic wr_check(input string name, input logic [3:0] a, input logic [31:0] d,
                          input logic [1:0] exp_r);
    logic [1:0] r;
    axi_write(a, d, 4'hF, r);
    check({name, "_resp"}, 32'(r), 32'(exp_r));
  endtask

  vec_t        vecs[10];
  logic [31:0] rd_d;
  logic [1:0]  rd_r;
  logic [1:0]  wr_r;

  initial begin
    vecs[0] = '{"status_reset", 1'b0, 4'h8, 32'h0, 4'h0, 32'h000A_0000, 2'b00};
    vecs[1] = '{"push_first",   1'b1, 4'h0, 32'hA5A5_0001, 4'hF, 32'h0, 2'b00};
    vecs[2] = '{"status_one",   1'b0, 4'h8, 32'h0, 4'h0, 32'h0008_0001, 2'b00};
    vecs[3] = '{"txdata_rd",    1'b0, 4'h0, 32'h0, 4'h0, 32'h0, 2'b00};
    vecs[4] = '{"strb0_push",   1'b1, 4'h0, 32'hDEAD_0000, 4'h0, 32'h0, 2'b00};
    vecs[5] = '{"status_strb0", 1'b0, 4'h8, 32'h0, 4'h0, 32'h0008_0001, 2'b00};
    vecs[6] = '{"rxdata_wr",    1'b1, 4'h4, 32'h1234, 4'hF, 32'h0, 2'b00};
    vecs[7] = '{"ctrl_rd0",     1'b0, 4'hC, 32'h0, 4'h0, 32'h0, 2'b00};
    vecs[8] = '{"ctrl_irqen",   1'b1, 4'hC, 32'h4, 4'hF, 32'h0, 2'b00};
`ifdef AXI_FIFO_BRIDGE_IRQ_EN
    vecs[9] = '{"ctrl_rd1",     1'b0, 4'hC, 32'h0, 4'h0, 32'h4, 2'b00};
`else
    vecs[9] = '{"ctrl_rd1",     1'b0, 4'hC, 32'h0, 4'h0, 32'h0, 2'b00};
`endif

    rst_n = 1'b0; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    tx_tready = 1'b0; rx_tdata = '0; rx_tvalid = 1'b0;

    // Reset values and ready rise after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 0);
    check("rst_rx_tready", 32'(rx_tready), 0);
    check("rst_tx_tvalid", 32'(tx_tvalid), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    rst_n = 1'b1;
    check("rel_awready_pre", 32'(awready), 0);
    @(posedge clk); #1;
    check("rel_awready", 32'(awready), 1);
    check("rel_wready", 32'(wready), 1);
    check("rel_arready", 32'(arready), 1);

    // Register access table.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, wr_r);
        check({vecs[i].name, "_bresp"}, 32'(wr_r), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, rd_d, rd_r);
        check({vecs[i].name, "_rdata"}, rd_d, vecs[i].exp_data);
        check({vecs[i].name, "_rresp"}, 32'(rd_r), 32'(vecs[i].exp_resp));
      end
    end
    check("tx_tvalid_one", 32'(tx_tvalid), 1);
    check("tx_tdata_one", tx_tdata, 32'hA5A5_0001);
    tx_tready = 1'b1;
    @(posedge clk); #1;
    tx_tready = 1'b0;
    check("tx_tvalid_popped", 32'(tx_tvalid), 0);

    // Overflow: 9 pushes into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) begin
      axi_write(4'h0, 32'h100 + 32'(i), 4'hF, wr_r);
      check($sformatf("ovf_push%0d", i), 32'(wr_r), (i == 8) ? 32'h2 : 32'h0);
    end
    check("ovf_head", tx_tdata, 32'h100);
    rd_check("ovf_status", 4'h8, 32'h0019_0008, 2'b00);
    wr_check("ovf_clr", 4'hC, 32'h2, 2'b00);
    rd_check("ovf_status_clr", 4'h8, 32'h0009_0008, 2'b00);
    wr_check("ovf_flush", 4'hC, 32'h1, 2'b00);
    rd_check("ovf_status_flush", 4'h8, 32'h000A_0000, 2'b00);

    // Flush racing a same-cycle core pop with 5 words queued.
    for (int i = 0; i < 5; i++) wr_check("fl_push", 4'h0, 32'h200 + 32'(i), 2'b00);
    rd_check("fl_status5", 4'h8, 32'h0008_0005, 2'b00);
    check("fl_ready", 32'(awready && wready), 1);
    awaddr = 4'hC; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; tx_tready = 1'b1;
    @(posedge clk); #1;
    tx_tready = 1'b0;
    check("fl_tvalid", 32'(tx_tvalid), 0);
    check("fl_bvalid", 32'(bvalid), 1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    rd_check("fl_status0", 4'h8, 32'h000A_0000, 2'b00);

    // RX path: two core words, three host reads, underflow is sticky across flush.
    check("rx_tready", 32'(rx_tready), 1);
    rx_tvalid = 1'b1; rx_tdata = 32'h11;
    @(posedge clk); #1;
    rx_tdata = 32'h22;
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
    rd_check("rx_rd0", 4'h4, 32'h11, 2'b00);
    rd_check("rx_rd1", 4'h4, 32'h22, 2'b00);
    rd_check("rx_rd2", 4'h4, 32'h0, 2'b10);
    rd_check("rx_status_unf", 4'h8, 32'h002A_0000, 2'b00);
    wr_check("rx_flush", 4'hC, 32'h1, 2'b00);
    rd_check("rx_status_keep", 4'h8, 32'h002A_0000, 2'b00);
    wr_check("rx_clr", 4'hC, 32'h2, 2'b00);
    rd_check("rx_status_clr", 4'h8, 32'h000A_0000, 2'b00);

    // RX full boundary.
    rx_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_tdata = 32'h300 + 32'(i);
      @(posedge clk); #1;
    end
    rx_tvalid = 1'b0;
    check("rx_full_tready", 32'(rx_tready), 0);
    rd_check("rx_full_status", 4'h8, 32'h0006_0800, 2'b00);
    wr_check("rx_full_flush", 4'hC, 32'h1, 2'b00);
    check("rx_flushed_tready", 32'(rx_tready), 1);

    // W three cycles ahead of AW, bready held low for four cycles.
    wdata = 32'hBEEF; wstrb = 4'hF; awaddr = 4'h0; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("wa_wready_drop", 32'(wready), 0);
    for (int i = 0; i < 2; i++) begin
      check("wa_awready_wait", 32'(awready), 1);
      @(posedge clk); #1;
    end
    awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("wa_awready_drop", 32'(awready), 0);
    check("wa_bvalid_pre", 32'(bvalid), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("wa_bvalid_hold", 32'(bvalid), 1);
      check("wa_bresp_hold", 32'(bresp), 0);
      check("wa_ready_low", 32'({awready, wready}), 0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("wa_bvalid_done", 32'(bvalid), 0);
    check("wa_ready_back", 32'({awready, wready}), 3);
    rd_check("wa_status", 4'h8, 32'h0008_0001, 2'b00);
    check("wa_tdata", tx_tdata, 32'hBEEF);

    // Reset in the middle of a held read and a half-accepted write.
    araddr = 4'h8; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("mr_rvalid", 32'(rvalid), 1);
    awaddr = 4'h0; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_rvalid_rst", 32'(rvalid), 0);
    check("mr_rdata_rst", rdata, 0);
    check("mr_tvalid_rst", 32'(tx_tvalid), 0);
    check("mr_ready_rst", 32'({awready, wready, arready, rx_tready}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_check("mr_status", 4'h8, 32'h000A_0000, 2'b00);
    wr_check("mr_push", 4'h0, 32'h77, 2'b00);
    rd_check("mr_status_push", 4'h8, 32'h0008_0001, 2'b00);
    check("mr_tdata", tx_tdata, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
